// File: rtl/intr_claim_ctrl_if.sv
// CPU-side claim/complete handshake of the interrupt claim controller.
// The CPU drives the master side and the controller sits on the slave side.
interface intr_claim_ctrl_if;
    logic       claim_req;
    logic       claim_ack;
    logic       claim_valid;
    logic [2:0] claim_id;
    logic       complete_req;
    logic [2:0] complete_id;

    modport master (
        output claim_req, complete_req, complete_id,
        input  claim_ack, claim_valid, claim_id
    );

    modport slave (
        input  claim_req, complete_req, complete_id,
        output claim_ack, claim_valid, claim_id
    );
endinterface

// File: rtl/intr_claim_ctrl.sv
// 8-source priority interrupt controller with nested preemption and a
// claim/complete handshake. Edge-triggered pending bits feed a max-priority winner.
module intr_claim_ctrl (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic [7:0]        irq_req,
    input  logic [23:0]       prio_cfg,
    input  logic [2:0]        threshold,
    input  logic              I_flag,
    output logic              intr_ev,
    output logic [7:0]        pending,
    output logic [7:0]        in_service,
    intr_claim_ctrl_if.slave  cpu
);
    localparam int NUM_SRC = 8;

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

    state_t                         r_state, w_state_nxt;
    logic [NUM_SRC-1:0]             r_irq_prev, r_pending, r_in_service;
    logic                           r_intr_ev;
    logic                           r_win_vld;
    logic [2:0]                     r_win_id;

    logic [NUM_SRC-1:0][2:0]        w_prio;
    logic [NUM_SRC-1:0]             w_rise, w_elig;
    logic [NUM_SRC-1:0]             w_grant_mask, w_cmp_mask;
    logic [2:0]                     w_run_prio, w_win_prio, w_win_id;
    logic                           w_win_vld, w_grant;

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
        assign w_prio[n] = prio_cfg[3*n +: 3];
        assign w_elig[n] = r_pending[n] & ~r_in_service[n] & (w_prio[n] != 3'd0)
                         & (w_prio[n] > threshold) & (w_prio[n] > w_run_prio);
    end

    assign w_rise = irq_req & ~r_irq_prev;

    always_comb begin
        w_run_prio = '0;
        for (int n = 0; n < NUM_SRC; n++)
            if (r_in_service[n] && w_prio[n] > w_run_prio)
                w_run_prio = w_prio[n];
    end

    // Strict '>' keeps the lowest index on a priority tie.
    always_comb begin
        w_win_prio = '0;
        w_win_id   = '0;
        for (int n = 0; n < NUM_SRC; n++)
            if (w_elig[n] && w_prio[n] > w_win_prio) begin
                w_win_prio = w_prio[n];
                w_win_id   = 3'(n);
            end
    end

    assign w_win_vld = |w_elig;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        cpu.claim_ack   = 1'b0;
        cpu.claim_valid = 1'b0;
        cpu.claim_id    = '0;
        w_grant         = 1'b0;
        case (r_state)
            S_IDLE: if (cpu.claim_req) w_state_nxt = S_ACK;
            S_ACK: begin
                cpu.claim_ack   = 1'b1;
                cpu.claim_valid = r_win_vld;
                cpu.claim_id    = r_win_vld ? r_win_id : 3'd0;
                w_grant         = r_win_vld;
                w_state_nxt     = S_HOLD;
            end
            S_HOLD: if (!cpu.claim_req) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Winner is frozen at the claim so config changes during ACK cannot retarget it.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_win_vld <= 1'b0;
            r_win_id  <= '0;
        end else if (r_state == S_IDLE && cpu.claim_req) begin
            r_win_vld <= w_win_vld;
            r_win_id  <= w_win_id;
        end
    end

    assign w_grant_mask = w_grant          ? (NUM_SRC'(1) << r_win_id)        : '0;
    assign w_cmp_mask   = cpu.complete_req ? (NUM_SRC'(1) << cpu.complete_id) : '0;

    // A new edge wins over a claim clear; grant wins over a same-cycle complete.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_irq_prev   <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_intr_ev    <= 1'b0;
        end else begin
            r_irq_prev   <= irq_req;
            r_pending    <= (r_pending & ~w_grant_mask) | w_rise;
            r_in_service <= (r_in_service & ~w_cmp_mask) | w_grant_mask;
            r_intr_ev    <= I_flag & w_win_vld;
        end
    end

    assign intr_ev    = r_intr_ev;
    assign pending    = r_pending;
    assign in_service = r_in_service;
endmodule
